// File: rtl/perm_output_serializer_if.sv
// Handshake bundle between the permutation core, the output serializer and the downstream beat consumer.
// The slave modport is the serializer's view; the master modport is the producer/consumer side.
interface perm_output_serializer_if #(
    parameter int OUT_W = 200,
    parameter int IX_W  = 3
);
    logic [4:0][4:0][63:0] statein;
    logic                  pushin;
    logic                  stopout;
    logic [OUT_W-1:0]      dout;
    logic [IX_W-1:0]       doutix;
    logic                  pushout;
    logic                  stopin;

    modport slave (
        input  statein, pushin, stopin,
        output stopout, dout, doutix, pushout
    );

    modport master (
        output statein, pushin, stopin,
        input  stopout, dout, doutix, pushout
    );
endinterface

// File: rtl/perm_output_serializer.sv
// Streams a 1600-bit Keccak state as NBEATS beats of OUT_W bits, with one active and one pending slot.
// Optional macro PERM_OUT_OVFL_EN adds a sticky ovfl output flagging pushes made while stopout is high.
module perm_output_serializer #(
    parameter int OUT_W  = 200,
    parameter int NBEATS = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef PERM_OUT_OVFL_EN
    output logic ovfl,
`endif
    perm_output_serializer_if.slave bus
);
    localparam int STATE_W = OUT_W * NBEATS;
    localparam int IX_W    = $clog2(NBEATS);
    localparam logic [IX_W-1:0] LAST_IX = IX_W'(NBEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        r_state;
    logic [STATE_W-1:0]            r_active;
    logic [STATE_W-1:0]            r_pend;
    logic                          r_pend_v;
    logic                          r_pushout;
    logic [IX_W-1:0]               r_ix;

    logic [STATE_W-1:0]            w_flat;
    logic [NBEATS-1:0][OUT_W-1:0]  w_beats;
    logic                          w_xfer;
    logic                          w_accept;
    logic                          w_last;

    // Lane L = x + 5*y occupies flat bits 64*L .. 64*L+63, mirroring the input loader.
    for (genvar x = 0; x < 5; x++) begin : g_x
        for (genvar y = 0; y < 5; y++) begin : g_y
            assign w_flat[64*(x+5*y) +: 64] = bus.statein[x][y];
        end
    end

    assign w_xfer   = r_pushout & ~bus.stopin;
    assign w_accept = bus.pushin & ~r_pend_v;
    assign w_last   = w_xfer && (r_ix == LAST_IX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_active  <= '0;
            r_pend    <= '0;
            r_pend_v  <= 1'b0;
            r_pushout <= 1'b0;
            r_ix      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_active  <= w_flat;
                        r_ix      <= '0;
                        r_pushout <= 1'b1;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (w_last) begin
                        // Reload on the final beat so consecutive states stream without a bubble.
                        if (r_pend_v) begin
                            r_active <= r_pend;
                            r_pend_v <= 1'b0;
                            r_ix     <= '0;
                        end else if (w_accept) begin
                            r_active <= w_flat;
                            r_ix     <= '0;
                        end else begin
                            r_pushout <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end else begin
                        if (w_xfer) r_ix <= r_ix + 1'b1;
                        if (w_accept) begin
                            r_pend   <= w_flat;
                            r_pend_v <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PERM_OUT_OVFL_EN
    logic r_ovfl;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       r_ovfl <= 1'b0;
        else if (bus.pushin && r_pend_v)  r_ovfl <= 1'b1;
    end
    assign ovfl = r_ovfl;
`endif

    assign w_beats     = r_active;
    assign bus.dout    = w_beats[r_ix];
    assign bus.doutix  = r_ix;
    assign bus.pushout = r_pushout;
    assign bus.stopout = r_pend_v;
endmodule

// File: tb/tb_perm_output_serializer.sv
// Directed bench for perm_output_serializer: beat scoreboard plus cycle-level handshake checks.
module tb_perm_output_serializer;
    typedef logic [4:0][4:0][63:0] st_t;
    typedef struct {logic [199:0] data; logic [2:0] ix;} beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    beat_t sb[$];
    logic [199:0] cap [8];
`ifdef PERM_OUT_OVFL_EN
    logic ovfl;
`endif

    perm_output_serializer_if bus();

    perm_output_serializer dut (
        .clk   (clk),
        .reset (reset),
`ifdef PERM_OUT_OVFL_EN
        .ovfl  (ovfl),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1599:0] flatten(input st_t s);
        logic [1599:0] f;
        f = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    f[64*(x+5*y)+z] = s[x][y][z];
        return f;
    endfunction

    task automatic push_model(input st_t s);
        logic [1599:0] f;
        f = flatten(s);
        for (int k = 0; k < 8; k++) sb.push_back('{f[200*k +: 200], 3'(k)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_st(input st_t s);
        bus.statein = s;
        bus.pushin  = 1'b1;
        tick();
        bus.pushin  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (bus.pushout && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 256'(bus.pushout), 256'(0));
        chk({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
        sb.delete();
    endtask

    // Every beat that will transfer on the coming edge is popped and compared.
    always @(negedge clk) begin
        beat_t e;
        if (reset && bus.pushout && !bus.stopin) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 256'(bus.doutix), 256'hdead);
            end else begin
                e = sb.pop_front();
                chk("beat_ix", 256'(bus.doutix), 256'(e.ix));
                chk("beat_data", 256'(bus.dout), 256'(e.data));
                cap[bus.doutix] = bus.dout;
            end
        end
    end

    initial begin
        st_t s1, sa, sb_st, sc, sd, sw;
        logic [1599:0] f;
        int cnt, wf, n;
        int walk [4] = '{0, 199, 200, 1599};

        bus.statein = '0;
        bus.pushin  = 1'b0;
        bus.stopin  = 1'b0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) begin
                s1[x][y] = {4'(x), 4'(y), 56'(x + 5*y)};
                sa[x][y] = {32'($urandom), 32'($urandom)};
                sb_st[x][y] = {32'($urandom), 32'($urandom)};
                sc[x][y] = {32'($urandom), 32'($urandom)};
                sd[x][y] = {32'($urandom), 32'($urandom)};
            end

        // Reset state
        #12;
        chk("rst_pushout", 256'(bus.pushout), 256'(0));
        chk("rst_doutix", 256'(bus.doutix), 256'(0));
        chk("rst_dout", 256'(bus.dout), 256'(0));
        chk("rst_stopout", 256'(bus.stopout), 256'(0));
`ifdef PERM_OUT_OVFL_EN
        chk("rst_ovfl", 256'(ovfl), 256'(0));
`endif
        tick();
        reset = 1'b1;
        tick();

        // Single state, one-cycle latency, 8 consecutive beats
        push_model(s1);
        push_st(s1);
        for (int i = 0; i < 8; i++) begin
            chk("single_pushout", 256'(bus.pushout), 256'(1));
            chk("single_ix", 256'(bus.doutix), 256'(i));
            tick();
        end
        chk("single_done", 256'(bus.pushout), 256'(0));
        chk("lane00", 256'(cap[0][63:0]), 256'(s1[0][0]));
        chk("lane30_lo", 256'(cap[0][199:192]), 256'(s1[3][0][7:0]));
        chk("lane44", 256'(cap[7][199:136]), 256'(s1[4][4]));
        drain("single");

        // Back-to-back, second push lands on the beat-7 transfer edge
        push_model(sa);
        push_st(sa);
        for (int i = 0; i < 16; i++) begin
            chk("b2b_pushout", 256'(bus.pushout), 256'(1));
            chk("b2b_stopout", 256'(bus.stopout), 256'(0));
            chk("b2b_ix", 256'(bus.doutix), 256'(i % 8));
            if (i == 7) begin
                push_model(sb_st);
                push_st(sb_st);
            end else begin
                tick();
            end
        end
        drain("b2b");

        // Stall on beat 3 for 5 cycles
        push_model(s1);
        push_st(s1);
        f = flatten(s1);
        cnt = 0;
        repeat (3) begin cnt += int'(bus.pushout); tick(); end
        chk("stall_at3", 256'(bus.doutix), 256'(3));
        bus.stopin = 1'b1;
        repeat (5) begin
            cnt += int'(bus.pushout);
            tick();
            chk("stall_ix_hold", 256'(bus.doutix), 256'(3));
            chk("stall_dout_hold", 256'(bus.dout), 256'(f[600 +: 200]));
        end
        bus.stopin = 1'b0;
        cnt += int'(bus.pushout);
        tick();
        chk("stall_resume_ix", 256'(bus.doutix), 256'(4));
        n = 0;
        while (bus.pushout && n < 40) begin cnt++; tick(); n++; end
        chk("stall_total", 256'(cnt), 256'(13));
        drain("stall");

        // Pending fill, overflow push ignored
        bus.stopin = 1'b1;
        push_model(sa);
        push_st(sa);
        chk("pend_stopout0", 256'(bus.stopout), 256'(0));
        push_model(sb_st);
        push_st(sb_st);
        chk("pend_stopout1", 256'(bus.stopout), 256'(1));
`ifdef PERM_OUT_OVFL_EN
        chk("ovfl_pre", 256'(ovfl), 256'(0));
`endif
        push_st(sc);
        chk("pend_stopout_hold", 256'(bus.stopout), 256'(1));
`ifdef PERM_OUT_OVFL_EN
        chk("ovfl_set", 256'(ovfl), 256'(1));
`endif
        bus.stopin = 1'b0;
        n = 0;
        while (bus.pushout && n < 40) begin
            chk("pend_stopout_seq", 256'(bus.stopout), 256'(n < 8 ? 1 : 0));
            tick();
            n++;
        end
        chk("pend_beats", 256'(n), 256'(16));
        drain("pend");

        // Reset mid-stream at beat 5
        push_model(sd);
        push_st(sd);
        repeat (5) tick();
        chk("mid_at5", 256'(bus.doutix), 256'(5));
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_pushout", 256'(bus.pushout), 256'(0));
        chk("mid_rst_dout", 256'(bus.dout), 256'(0));
        chk("mid_rst_ix", 256'(bus.doutix), 256'(0));
        chk("mid_rst_stopout", 256'(bus.stopout), 256'(0));
        tick();
        reset = 1'b1;
        tick();
        push_model(sd);
        push_st(sd);
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_ix", 256'(bus.doutix), 256'(i));
            tick();
        end
        drain("post_rst");

        // All ones
        sw = '1;
        for (int k = 0; k < 8; k++) sb.push_back('{'1, 3'(k)});
        push_st(sw);
        drain("ones");

        // Walking one across beat boundaries
        for (int w = 0; w < 4; w++) begin
            wf = walk[w];
            sw = '0;
            sw[(wf/64)%5][(wf/64)/5][wf%64] = 1'b1;
            for (int k = 0; k < 8; k++)
                sb.push_back('{(k == wf/200) ? (200'(1) << (wf % 200)) : 200'(0), 3'(k)});
            push_st(sw);
            drain("walk");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
